// File: rtl/control_unit.sv
// control_unit
//   Sequencer for the vector-distance machine. Walks two operand vectors held in
//   combinational-read RAMs, presents the element addresses, strobes the squarer
//   and accumulator once per element, stops on a zero element of vector 1 or after
//   MAX_LEN elements, then strobes the result store and raises Done until start drops.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   level request to begin a run (sampled in IDLE and DONE only)
//   data_1    in   RAM1 word at Adress1, same-cycle read; zero is the end sentinel
//   data_2    in   RAM2 word at Adress2; consumed by the datapath only
//   Adress1   out  vector-1 element address = BASE1 + idx (wraps)
//   Adress2   out  vector-2 element address = BASE2 + idx (wraps)
//   E_Square  out  squarer enable, one cycle per element
//   E_Sum     out  accumulator enable, one cycle per element
//   Store_D   out  result store strobe, one cycle per run
//   Done      out  run complete, held until start returns low
module control_unit #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned BASE1   = 0,
   parameter int unsigned BASE2   = 256,
   parameter int unsigned MAX_LEN = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_1,
   input  logic [DATA_W-1:0] data_2,
   output logic [ADDR_W-1:0] Adress1,
   output logic [ADDR_W-1:0] Adress2,
   output logic              E_Square,
   output logic              E_Sum,
   output logic              Store_D,
   output logic              Done
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StSquare,
      StSum,
      StStore,
      StDone
   } state_e;

   localparam logic [ADDR_W-1:0] Base1   = ADDR_W'(BASE1);
   localparam logic [ADDR_W-1:0] Base2   = ADDR_W'(BASE2);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MAX_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // Vector-2 data only feeds the datapath; the sentinel is taken from vector 1.
   logic unused_data_2;
   assign unused_data_2 = ^data_2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      E_Square = 1'b0;
      E_Sum    = 1'b0;
      Store_D  = 1'b0;
      Done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (start) state_d = StFetch;
         end
         StFetch: begin
            // A zero element ends the vector and is not itself processed.
            if (data_1 == '0) state_d = StStore;
            else              state_d = StSquare;
         end
         StSquare: begin
            E_Square = 1'b1;
            state_d  = StSum;
         end
         StSum: begin
            E_Sum = 1'b1;
            if (idx_q == LastIdx) begin
               state_d = StStore;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StFetch;
            end
         end
         StStore: begin
            Store_D = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            Done = 1'b1;
            // Hold until start drops so a held request cannot retrigger a run.
            if (!start) begin
               idx_d   = '0;
               state_d = StIdle;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   assign Adress1 = Base1 + idx_q;
   assign Adress2 = Base2 + idx_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit (MAX_LEN reduced to 4 so the length limit is reachable).
// Table-driven per-cycle vectors plus hand sequences for async reset and abort/restart.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [23:0] data_1;
   logic [23:0] data_2;
   logic [8:0]  Adress1;
   logic [8:0]  Adress2;
   logic        E_Square;
   logic        E_Sum;
   logic        Store_D;
   logic        Done;

   logic [23:0] mem1 [512];
   logic [23:0] mem2 [512];

   assign data_1 = mem1[Adress1];
   assign data_2 = mem2[Adress2];

   control_unit #(
      .DATA_W  (24),
      .ADDR_W  (9),
      .BASE1   (0),
      .BASE2   (256),
      .MAX_LEN (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_1   (data_1),
      .data_2   (data_2),
      .Adress1  (Adress1),
      .Adress2  (Adress2),
      .E_Square (E_Square),
      .E_Sum    (E_Sum),
      .Store_D  (Store_D),
      .Done     (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe patterns {E_Square, E_Sum, Store_D, Done}
   localparam logic [3:0] SN = 4'b0000;
   localparam logic [3:0] SQ = 4'b1000;
   localparam logic [3:0] SM = 4'b0100;
   localparam logic [3:0] ST = 4'b0010;
   localparam logic [3:0] DN = 4'b0001;

   typedef struct {
      logic        start;
      logic        we;
      int          wa;
      logic [23:0] wd;
      int          a1;
      logic [3:0]  s;
   } vec_t;

   vec_t tbl [64];
   int   n_vec;
   int   checks;
   int   errors;

   task automatic add_vec(input logic st, input logic we, input int wa, input logic [23:0] wd,
                          input int a1, input logic [3:0] s);
      tbl[n_vec].start = st;
      tbl[n_vec].we    = we;
      tbl[n_vec].wa    = wa;
      tbl[n_vec].wd    = wd;
      tbl[n_vec].a1    = a1;
      tbl[n_vec].s     = s;
      n_vec++;
   endtask

   function automatic logic [21:0] expv(input int a1, input logic [3:0] s);
      logic [8:0] a;
      logic [8:0] b;
      a = 9'(a1);
      b = 9'(a1 + 256);
      return {a, b, s};
   endfunction

   function automatic logic [21:0] outs();
      return {Adress1, Adress2, E_Square, E_Sum, Store_D, Done};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int store_cnt;
      int store_cyc;
      int done_cyc;

      checks = 0;
      errors = 0;
      n_vec  = 0;
      for (int i = 0; i < 512; i++) begin
         mem1[i] = 24'd7;
         mem2[i] = 24'(i);
      end
      mem2[256] = 24'd12;
      mem2[257] = 24'd32;
      mem2[258] = 24'd21;

      // Run A: 31, 50, 0 -> two elements, sentinel at address 2
      add_vec(0, 1, 0, 24'd31, 0, SN);
      add_vec(0, 1, 1, 24'd50, 0, SN);
      add_vec(0, 1, 2, 24'd0,  0, SN);
      add_vec(1, 0, 0, 0, 0, SN);   // cycle 1 FETCH
      add_vec(1, 0, 0, 0, 0, SQ);
      add_vec(1, 0, 0, 0, 0, SM);
      add_vec(1, 0, 0, 0, 1, SN);
      add_vec(1, 0, 0, 0, 1, SQ);
      add_vec(1, 0, 0, 0, 1, SM);
      add_vec(1, 0, 0, 0, 2, SN);   // sentinel fetched
      add_vec(1, 0, 0, 0, 2, ST);   // cycle 8
      add_vec(1, 0, 0, 0, 2, DN);   // cycle 9
      add_vec(1, 0, 0, 0, 2, DN);   // start held: Done stays
      add_vec(1, 0, 0, 0, 2, DN);
      add_vec(0, 0, 0, 0, 0, SN);   // start low -> IDLE, idx cleared
      add_vec(0, 0, 0, 0, 0, SN);
      // Run B: sentinel first -> no square/sum
      add_vec(0, 1, 0, 24'd0, 0, SN);
      add_vec(1, 0, 0, 0, 0, SN);
      add_vec(1, 0, 0, 0, 0, ST);
      add_vec(1, 0, 0, 0, 0, DN);
      add_vec(0, 0, 0, 0, 0, SN);
      // Run C: no sentinel in range, stops at MAX_LEN=4; start dropped mid-run is ignored
      add_vec(0, 1, 0, 24'd5, 0, SN);
      add_vec(0, 1, 2, 24'd9, 0, SN);
      add_vec(1, 0, 0, 0, 0, SN);
      add_vec(1, 0, 0, 0, 0, SQ);
      add_vec(1, 0, 0, 0, 0, SM);
      add_vec(0, 0, 0, 0, 1, SN);
      add_vec(0, 0, 0, 0, 1, SQ);
      add_vec(0, 0, 0, 0, 1, SM);
      add_vec(0, 0, 0, 0, 2, SN);
      add_vec(0, 0, 0, 0, 2, SQ);
      add_vec(0, 0, 0, 0, 2, SM);
      add_vec(0, 0, 0, 0, 3, SN);
      add_vec(0, 0, 0, 0, 3, SQ);
      add_vec(1, 0, 0, 0, 3, SM);
      add_vec(1, 0, 0, 0, 3, ST);   // no FETCH of address 4
      add_vec(1, 0, 0, 0, 3, DN);
      add_vec(1, 0, 0, 0, 3, DN);
      add_vec(0, 0, 0, 0, 0, SN);

      // Power-on reset is seen before any clock edge
      rst   = 1'b0;
      start = 1'b0;
      #2;
      check("por", outs(), expv(0, SN));
      @(posedge clk);
      #3 rst = 1'b1;

      for (int i = 0; i < n_vec; i++) begin
         if (tbl[i].we) mem1[tbl[i].wa] = tbl[i].wd;
         start = tbl[i].start;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), outs(), expv(tbl[i].a1, tbl[i].s));
      end

      // Abort in SQUARE with an async reset, then restart from address 0
      start = 1'b1;
      @(posedge clk);
      #1;
      check("abort_fetch", outs(), expv(0, SN));
      @(posedge clk);
      #1;
      check("abort_square", outs(), expv(0, SQ));
      #3 rst = 1'b0;
      #1;
      check("async_rst", outs(), expv(0, SN));
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_hold%0d", k), outs(), expv(0, SN));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("restart_fetch", outs(), expv(0, SN));

      store_cnt = 0;
      store_cyc = -1;
      done_cyc  = -1;
      for (int c = 2; c < 40 && done_cyc < 0; c++) begin
         @(posedge clk);
         #1;
         if (Store_D) begin
            store_cnt++;
            store_cyc = c;
         end
         if (Done) done_cyc = c;
      end
      check("restart_store_cnt", 22'(store_cnt), 22'd1);
      check("restart_store_cyc", 22'(store_cyc), 22'd13);
      check("restart_done_cyc", 22'(done_cyc), 22'd14);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("final_idle", outs(), expv(0, SN));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
